digit_frame_loader: RTL and testbench
=====================================

# digit_frame_loader

Writer side of the display digit bus. Accepts a full frame of six 5-bit digit codes through a valid/ready handshake and serialises it onto the `digit`/`latch` pair feeding the display scanner's six-stage shift register. Each falling edge of `latch` shifts one digit in. The block sits between the clock/time-keeping logic and the display scanner.

## Interface
Parameters:
- `NUM_DIGITS`, 6: digits per frame; must match scanner depth.
- `DIGIT_W`, 5: width of one digit code; codes pass through unmodified.
- `SETUP_CYC`, 2: cycles `digit` is stable before `latch` rises (≥1).
- `PULSE_CYC`, 2: cycles `latch` is high (≥1).
- `HOLD_CYC`, 2: cycles `digit` stays stable after `latch` falls (≥1).

Ports:
- `clk`, in, 1: single clock. All logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `load_valid`, in, 1: a frame is offered.
- `load_ready`, out, 1: block can accept a frame.
- `load_digits`, in, `NUM_DIGITS*DIGIT_W`: position p occupies bits `[p*DIGIT_W +: DIGIT_W]`.
- `digit`, out, `DIGIT_W`: registered digit code to the scanner.
- `latch`, out, 1: registered strobe. Idle low; the scanner captures on its falling edge.
- `busy`, out, 1: a frame is in flight.
- `frame_done`, out, 1: one-cycle pulse after the last digit's hold phase.

## Operation
- Reset values: `digit`=0, `latch`=0, `busy`=0, `frame_done`=0, `load_ready`=1, FSM in IDLE.
- `load_ready` = (state == IDLE). The block is not pipelined, so a new frame is refused until the current one completes.
- Accept happens when `load_valid && load_ready` on a clock edge:
  - `load_digits` is copied into an internal frame register.
  - The index is set to `NUM_DIGITS-1`.
  - `digit` takes `load_digits[NUM_DIGITS-1]` and the FSM moves to SETUP.
- Send order is highest position first, so after `NUM_DIGITS` shifts, scanner stage p holds `load_digits[p]`.
- FSM states and transitions:
  - IDLE → SETUP on accept.
  - SETUP: `latch`=0 for `SETUP_CYC` cycles → HIGH.
  - HIGH: `latch`=1 for `PULSE_CYC` cycles → HOLD.
  - HOLD: `latch`=0 for `HOLD_CYC` cycles.
    - If index > 0: decrement index, load next digit into `digit`, go to SETUP.
    - If index = 0: go to DONE.
  - DONE: `frame_done`=1 for one cycle → IDLE.
- `digit` changes only on the HOLD→SETUP and IDLE→SETUP transitions. It is never changed while `latch`=1 or in the cycle `latch` falls.
- After a frame, `digit` retains the last value sent (position 0).
- `busy` = 1 in SETUP, HIGH, HOLD and DONE.
- Phase timer: one down-counter of width `$clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC)+1)`, reloaded on every state entry.
- Index counter: `$clog2(NUM_DIGITS)` bits; it never wraps below 0.
- `load_valid` outside IDLE is ignored; `load_digits` may change freely after accept.
- Reset mid-frame: all outputs return to reset values immediately and asynchronously, and the partial frame is discarded.
  - If `latch` was high, the forced fall may shift an undefined digit into the scanner. This is accepted.
  - Upstream must re-send a full frame after reset.

## Timing
- Accept edge to first `latch` rise: `SETUP_CYC` cycles.
- Per-digit period: `SETUP_CYC+PULSE_CYC+HOLD_CYC` cycles (6 with defaults).
- Frame: `NUM_DIGITS*(S+P+H)` cycles from accept to `frame_done` high. Defaults: 36 cycles, so `frame_done` is high in cycle 36 after accept.
- `load_ready` returns to 1 one cycle after `frame_done`. The minimum accept-to-accept interval is therefore frame+2 cycles.
- All outputs are registered, with no combinational path from inputs to outputs except `load_ready`, which depends on state only.

## Structure
- Shared `display_pkg` holds `NUM_DIGITS`, `DIGIT_W`, the digit typedef `logic [DIGIT_W-1:0]`, and the FSM state enum. The scanner shares the first three.
- Single flat module, no sub-module; the phase timer is too small to split out.

## Test plan
- Reset and basic frame:
  - Stimulus: hold `rst_n`=0, then release; load positions 5..0 = 1,2,3,4,5,6.
  - Required: `latch` falling edges carry 1,2,3,4,5,6 in order; a 6-stage shift model ends with stage p = `load_digits[p]`; `frame_done` appears exactly 36 cycles after accept.
- Timing check with S=1, P=3, H=2:
  - Required: `digit` is stable for 1 cycle before each rise, `latch` is high for exactly 3 cycles, `digit` is unchanged for 2 cycles after each fall; frame length is 36 cycles.
- Back-to-back frames with `load_valid` held high:
  - Required: the second accept occurs one cycle after `frame_done`; a changed `load_digits` during the first frame does not affect it.
- Mid-frame reset: assert `rst_n`=0 during a HIGH phase of digit 3.
  - Required: `latch`, `digit`, `busy` and `frame_done` are 0 and `load_ready` is 1 immediately.
  - Required: a new frame after release completes normally.
- Full-range codes: load 31 and 0 alternating.
  - Required: values pass through bit-exact, and no `latch` glitch occurs when `digit` toggles all bits.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display bus definitions: digit geometry, digit code type and the
// frame loader's FSM state encoding.
package display_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int DIGIT_W    = 5;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_HOLD,
    ST_DONE
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/digit_frame_loader.sv
// Serialises a six-digit frame onto the digit/latch pair of the display
// scanner, highest position first, one digit per latch pulse.
module digit_frame_loader #(
  parameter int NUM_DIGITS = display_pkg::NUM_DIGITS,
  parameter int DIGIT_W    = display_pkg::DIGIT_W,
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 2,
  parameter int HOLD_CYC   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] load_digits,
  output logic [DIGIT_W-1:0]            digit,
  output logic                          latch,
  output logic                          busy,
  output logic                          frame_done
);
  import display_pkg::*;

  localparam int TW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TW-1:0] SETUP_RLD = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] PULSE_RLD = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] HOLD_RLD  = TW'(HOLD_CYC - 1);
  localparam logic [IW-1:0] IDX_TOP   = IW'(NUM_DIGITS - 1);

  state_t                               state_q, state_d;
  logic [TW-1:0]                        tmr_q, tmr_d;
  logic [IW-1:0]                        idx_q, idx_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   frame_q, frame_d;
  logic [DIGIT_W-1:0]                   digit_d;
  logic                                 tmr_zero;

  assign load_ready = (state_q == ST_IDLE);
  assign tmr_zero   = (tmr_q == '0);

  // Timer is reloaded with (cycles-1) on every state entry; a state exits
  // on the cycle its timer reads zero.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_zero ? tmr_q : tmr_q - 1'b1;
    idx_d   = idx_q;
    frame_d = frame_q;
    digit_d = digit;
    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (load_valid) begin
          frame_d = load_digits;
          idx_d   = IDX_TOP;
          digit_d = load_digits[NUM_DIGITS*DIGIT_W-1 -: DIGIT_W];
          state_d = ST_SETUP;
          tmr_d   = SETUP_RLD;
        end
      end
      ST_SETUP: if (tmr_zero) begin
        state_d = ST_HIGH;
        tmr_d   = PULSE_RLD;
      end
      ST_HIGH: if (tmr_zero) begin
        state_d = ST_HOLD;
        tmr_d   = HOLD_RLD;
      end
      ST_HOLD: if (tmr_zero) begin
        if (idx_q != '0) begin
          idx_d   = idx_q - 1'b1;
          digit_d = frame_q[idx_q - 1'b1];
          state_d = ST_SETUP;
          tmr_d   = SETUP_RLD;
        end else begin
          state_d = ST_DONE;
          tmr_d   = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit      <= '0;
      latch      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      digit      <= digit_d;
      latch      <= (state_d == ST_HIGH);
      busy       <= (state_d != ST_IDLE);
      frame_done <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_digit_frame_loader.sv
// Randomised bench: two loaders (default timing and S=1/P=3/H=2) checked
// cycle by cycle against an arithmetic waveform model and a shift model.
module tb_digit_frame_loader;
  localparam int N  = 6;
  localparam int W  = 5;
  localparam int LW = N*W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          lv_a, rdy_a, lat_a, busy_a, fd_a;
  logic [LW-1:0] ld_a;
  logic [W-1:0]  dg_a;
  logic          lv_b, rdy_b, lat_b, busy_b, fd_b;
  logic [LW-1:0] ld_b;
  logic [W-1:0]  dg_b;

  digit_frame_loader #(.NUM_DIGITS(N), .DIGIT_W(W), .SETUP_CYC(2), .PULSE_CYC(2), .HOLD_CYC(2)) u_a (
    .clk(clk), .rst_n(rst_n), .load_valid(lv_a), .load_ready(rdy_a), .load_digits(ld_a),
    .digit(dg_a), .latch(lat_a), .busy(busy_a), .frame_done(fd_a));

  digit_frame_loader #(.NUM_DIGITS(N), .DIGIT_W(W), .SETUP_CYC(1), .PULSE_CYC(3), .HOLD_CYC(2)) u_b (
    .clk(clk), .rst_n(rst_n), .load_valid(lv_b), .load_ready(rdy_b), .load_digits(ld_b),
    .digit(dg_b), .latch(lat_b), .busy(busy_b), .frame_done(fd_b));

  int sel;
  logic         o_rdy, o_lat, o_busy, o_fd;
  logic [W-1:0] o_dg;
  always_comb begin
    o_rdy  = sel != 0 ? rdy_b  : rdy_a;
    o_lat  = sel != 0 ? lat_b  : lat_a;
    o_busy = sel != 0 ? busy_b : busy_a;
    o_fd   = sel != 0 ? fd_b   : fd_a;
    o_dg   = sel != 0 ? dg_b   : dg_a;
  end

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s (dut %0d): got %0d expected %0d at %0t", tag, sel, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [LW-1:0] d);
    if (sel != 0) begin lv_b = v; ld_b = d; end
    else          begin lv_a = v; ld_a = d; end
  endtask

  function automatic logic [LW-1:0] rnd_frame();
    logic [LW-1:0] r;
    r = LW'({$urandom(), $urandom()});
    return r;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_latch"}, o_lat, 0);
    chk({tag, "_digit"}, o_dg, 0);
    chk({tag, "_busy"},  o_busy, 0);
    chk({tag, "_done"},  o_fd, 0);
    chk({tag, "_ready"}, o_rdy, 1);
  endtask

  // Offers frame d on the selected DUT and checks every cycle until idle.
  // abort_c >= 0 pulls reset at that cycle after accept instead.
  task automatic run_frame(input logic [LW-1:0] d, input bit keep_valid, input int abort_c);
    int s, p, h, per, k, ph, last;
    int stage [N];
    logic [W-1:0] e_dg;
    bit e_lat, e_busy, e_fd, e_rdy, prev_lat;
    s = (sel != 0) ? 1 : 2;
    p = (sel != 0) ? 3 : 2;
    h = 2;
    per  = s + p + h;
    last = N * per;
    for (int i = 0; i < N; i++) stage[i] = -1;
    prev_lat = 1'b0;
    chk("ready_before_accept", o_rdy, 1);
    drive(1'b1, d);
    @(posedge clk);
    #1 drive(keep_valid, rnd_frame());
    for (int c = 0; c <= last + 1; c++) begin
      @(negedge clk);
      if (c == abort_c) begin
        rst_n = 1'b0;
        #1 chk_reset_state("midframe_reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, '0);
        return;
      end
      if (c < last) begin
        k = c / per; ph = c % per;
        e_lat = (ph >= s) && (ph < s + p);
        e_dg  = d[(N-1-k)*W +: W];
        e_busy = 1'b1; e_fd = 1'b0; e_rdy = 1'b0;
      end else if (c == last) begin
        e_lat = 1'b0; e_dg = d[W-1:0];
        e_busy = 1'b1; e_fd = 1'b1; e_rdy = 1'b0;
      end else begin
        e_lat = 1'b0; e_dg = d[W-1:0];
        e_busy = 1'b0; e_fd = 1'b0; e_rdy = 1'b1;
      end
      chk("latch", o_lat, int'(e_lat));
      chk("digit", o_dg, int'(e_dg));
      chk("busy", o_busy, int'(e_busy));
      chk("frame_done", o_fd, int'(e_fd));
      chk("load_ready", o_rdy, int'(e_rdy));
      if (prev_lat && !o_lat) begin
        for (int i = N-1; i > 0; i--) stage[i] = stage[i-1];
        stage[0] = int'(o_dg);
      end
      prev_lat = o_lat;
      if (c < last && (c % 5) == 2) drive(keep_valid, rnd_frame());
    end
    for (int i = 0; i < N; i++) chk("scanner_stage", stage[i], int'(d[i*W +: W]));
    if (!keep_valid) drive(1'b0, '0);
  endtask

  initial begin
    logic [LW-1:0] f;
    rst_n = 1'b0;
    lv_a = 1'b0; ld_a = '0; lv_b = 1'b0; ld_b = '0;
    sel = 0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset_a");
    sel = 1;
    #1 chk_reset_state("reset_b");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    f = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
    sel = 0; #1 run_frame(f, 1'b0, -1);
    sel = 1; #1 run_frame(f, 1'b0, -1);

    // all-bits toggling codes through both timings
    f = {5'd31, 5'd0, 5'd31, 5'd0, 5'd31, 5'd0};
    sel = 0; #1 run_frame(f, 1'b0, -1);
    sel = 1; #1 run_frame(~f, 1'b0, -1);

    // back-to-back with load_valid held high
    sel = 0; #1;
    run_frame(rnd_frame(), 1'b1, -1);
    run_frame(rnd_frame(), 1'b1, -1);
    run_frame(rnd_frame(), 1'b0, -1);

    // reset during the high phase of the third digit sent
    @(negedge clk);
    run_frame(rnd_frame(), 1'b0, 2*6 + 2);
    chk_reset_state("after_release");
    run_frame(rnd_frame(), 1'b0, -1);
    sel = 1; #1 chk_reset_state("after_release_b");
    run_frame(rnd_frame(), 1'b0, -1);

    for (int n = 0; n < 8; n++) begin
      sel = int'($urandom_range(0, 1));
      #1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame(rnd_frame(), 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
